// File: rtl/knn_mem_arbiter.sv
// rtl/knn_mem_arbiter.sv - two-requester arbiter for the shared KNN memory port
//
// Serialises read/write commands from requester 0 (KNN memory controller) and
// requester 1 (host loader) onto a single memory port, supports locked bursts
// and routes fixed-latency read returns back to the issuing requester.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined     : simultaneous requests in IDLE go to the requester that was
//                 not granted most recently (first tie after reset -> m0).
//   not defined : fixed priority, m0 always wins a tie.
//
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   mX_read / mX_write           command request, held until mX_grant
//   mX_lock                      keep port ownership after the current grant
//   mX_addr / mX_wdata           command operands
//   mX_grant                     one-cycle pulse, command accepted and issued
//   mX_rvalid / mX_rdata         read return pulse and data (data held)
//   mem_read / mem_write         single-cycle memory strobes
//   mem_address / mem_writedata  registered command operands
//   mem_readdata                 memory read data, valid RD_LAT cycles after mem_read
//   owner                        2'b00 none, 2'b01 m0, 2'b10 m1
//   cmd_err                      sticky: a requester asserted read and write together

module knn_mem_arbiter #(
  parameter int W        = 32,
  parameter int ADDR_W   = 16,
  parameter int RD_LAT   = 2,
  parameter int MAX_LOCK = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_read,
  input  logic              m0_write,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [W-1:0]      m0_wdata,
  output logic              m0_grant,
  output logic              m0_rvalid,
  output logic [W-1:0]      m0_rdata,

  input  logic              m1_read,
  input  logic              m1_write,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [W-1:0]      m1_wdata,
  output logic              m1_grant,
  output logic              m1_rvalid,
  output logic [W-1:0]      m1_rdata,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [W-1:0]      mem_writedata,
  input  logic [W-1:0]      mem_readdata,

  output logic [1:0]        owner,
  output logic              cmd_err
);

  localparam int LCW = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] LOCK_LIMIT = LCW'(MAX_LOCK);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;

  logic             pend0, pend1;
  logic             tie_id;
  logic             issue;
  logic             issue_id;

  logic             sel_rd, sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [W-1:0]     sel_wdata;

  // Requester id of the command currently on the memory port.
  logic             port_id_q;

  // Read-return tag pipeline: one {valid, id} slot per cycle of memory latency.
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_id;

  assign pend0 = m0_read | m0_write;
  assign pend1 = m1_read | m1_write;

`ifdef ARB_ROUND_ROBIN_EN
  // Id of the most recently granted requester; starts at m1 so the first tie goes to m0.
  logic last_q;

  assign tie_id = ~last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (issue) begin
      last_q <= issue_id;
    end
  end
`else
  assign tie_id = 1'b0;
`endif

  // Next-state / issue decision.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    issue      = 1'b0;
    issue_id   = 1'b0;

    case (state_q)
      IDLE: begin
        lock_cnt_d = '0;
        if (pend0 || pend1) begin
          issue      = 1'b1;
          issue_id   = (pend0 && pend1) ? tie_id : pend1;
          state_d    = issue_id ? OWN1 : OWN0;
          lock_cnt_d = LCW'(1);
        end
      end

      OWN0: begin
        // Lock is checked in the cycle the previous grant is visible, so a
        // requester drops lock together with its last request.
        if (!m0_lock || (lock_cnt_q >= LOCK_LIMIT)) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (pend0) begin
          issue      = 1'b1;
          issue_id   = 1'b0;
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end

      OWN1: begin
        if (!m1_lock || (lock_cnt_q >= LOCK_LIMIT)) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (pend1) begin
          issue      = 1'b1;
          issue_id   = 1'b1;
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end

      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Operand mux for the selected requester.
  always_comb begin
    sel_rd    = m0_read;
    sel_wr    = m0_write;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (issue_id) begin
      sel_rd    = m1_read;
      sel_wr    = m1_write;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  always_comb begin
    case (state_q)
      OWN0:    owner = 2'b01;
      OWN1:    owner = 2'b10;
      default: owner = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      lock_cnt_q    <= '0;
      m0_grant      <= 1'b0;
      m1_grant      <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      port_id_q     <= 1'b0;
      cmd_err       <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      m0_grant   <= issue & ~issue_id;
      m1_grant   <= issue & issue_id;
      // A combined read+write becomes a write only; the read half is dropped.
      mem_read   <= issue & sel_rd & ~sel_wr;
      mem_write  <= issue & sel_wr;
      if (issue) begin
        mem_address   <= sel_addr;
        mem_writedata <= sel_wdata;
        port_id_q     <= issue_id;
      end
      if (issue && sel_rd && sel_wr) begin
        cmd_err <= 1'b1;
      end
    end
  end

  // Tags enter when the read strobe is on the port; the slot leaving the last
  // stage lines up with mem_readdata, which is captured on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v     <= '0;
      tag_id    <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      tag_v[0]  <= mem_read;
      tag_id[0] <= port_id_q;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end

      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (tag_v[RD_LAT-1]) begin
        if (tag_id[RD_LAT-1]) begin
          m1_rvalid <= 1'b1;
          m1_rdata  <= mem_readdata;
        end else begin
          m0_rvalid <= 1'b1;
          m0_rdata  <= mem_readdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_knn_mem_arbiter.sv
// tb/tb_knn_mem_arbiter.sv - scoreboard bench for knn_mem_arbiter
//
// Stimulus pushes expected port events (cycle, strobes, operands, read data)
// into a queue; a negedge monitor pops one entry per cycle with activity.

module tb_knn_mem_arbiter;

  localparam int W        = 32;
  localparam int ADDR_W   = 16;
  localparam int RD_LAT   = 2;
  localparam int MAX_LOCK = 64;

  localparam logic [5:0] EV_G0  = 6'b100000;
  localparam logic [5:0] EV_G1  = 6'b010000;
  localparam logic [5:0] EV_MR  = 6'b001000;
  localparam logic [5:0] EV_MW  = 6'b000100;
  localparam logic [5:0] EV_RV0 = 6'b000010;
  localparam logic [5:0] EV_RV1 = 6'b000001;

  logic              clk;
  logic              rst;
  logic              m0_read, m0_write, m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic [W-1:0]      m0_wdata;
  logic              m0_grant, m0_rvalid;
  logic [W-1:0]      m0_rdata;
  logic              m1_read, m1_write, m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [W-1:0]      m1_wdata;
  logic              m1_grant, m1_rvalid;
  logic [W-1:0]      m1_rdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [W-1:0]      mem_writedata;
  logic [W-1:0]      mem_readdata;
  logic [1:0]        owner;
  logic              cmd_err;

  knn_mem_arbiter #(
    .W(W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_read(m0_read), .m0_write(m0_write), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_grant(m0_grant), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_grant(m1_grant), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata),
    .owner(owner), .cmd_err(cmd_err)
  );

  typedef struct {
    int          cyc;
    logic [5:0]  ev;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_sched[int];
  int          cyc;
  int          n_checks;
  int          n_fail;
  logic [5:0]  mon_ev;
  exp_t        mon_e;

  initial begin
    clk = 1'b0;
    cyc = 0;
    forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
    end
  end

  function automatic logic [31:0] mem_val(input logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEAD_BEEF : {16'hA5A5, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [5:0] ev, input logic [15:0] a,
                      input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.cyc = c; e.ev = ev; e.addr = a; e.wdata = wd; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: data appears RD_LAT cycles after the read strobe.
  initial begin
    mem_readdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_readdata = rd_sched.exists(cyc) ? rd_sched[cyc] : 32'h0;
    end
  end

  // Monitor.
  always @(negedge clk) begin
    mon_ev = {m0_grant, m1_grant, mem_read, mem_write, m0_rvalid, m1_rvalid};
    if (mem_read) rd_sched[cyc + RD_LAT] = mem_val(mem_address);
    if (mon_ev != 6'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 64'(mon_ev), 64'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("event_kind", 64'(mon_ev), 64'(mon_e.ev));
        if (mem_read || mem_write) chk("mem_address", 64'(mem_address), 64'(mon_e.addr));
        if (mem_write) chk("mem_writedata", 64'(mem_writedata), 64'(mon_e.wdata));
        if (m0_rvalid) chk("m0_rdata", 64'(m0_rdata), 64'(mon_e.rdata));
        if (m1_rvalid) chk("m1_rdata", 64'(m1_rdata), 64'(mon_e.rdata));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic        wid, pid;
    logic [15:0] waddr, paddr;

    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    m0_read = 0; m0_write = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_read = 0; m1_write = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_grants", 64'({m0_grant, m1_grant, m0_rvalid, m1_rvalid}), 64'h0);
    chk("rst_strobes", 64'({mem_read, mem_write, cmd_err}), 64'h0);
    chk("rst_owner", 64'(owner), 64'h0);
    chk("rst_mem_address", 64'(mem_address), 64'h0);
    chk("rst_rdata", 64'({m0_rdata, m1_rdata}), 64'h0);
    step();
    rst = 1'b0;

    // Single m0 read, return after RD_LAT
    step(); t = cyc;
    m0_read = 1; m0_addr = 16'h0010;
    push(t + 1, EV_G0 | EV_MR, 16'h0010, 32'h0, 32'h0);
    push(t + 4, EV_RV0, 16'h0, 32'h0, 32'hDEAD_BEEF);
    step(); m0_read = 0;
    repeat (6) step();
    @(negedge clk);
    chk("t1_m0_rdata_held", 64'(m0_rdata), 64'hDEAD_BEEF);
    chk("t1_m1_rdata", 64'(m1_rdata), 64'h0);

    // m1 locked 4-word write burst with m0 read waiting
    step(); t = cyc;
    m1_write = 1; m1_lock = 1; m1_addr = 16'h0100; m1_wdata = 32'hC0DE_0000;
    for (int i = 0; i < 4; i++)
      push(t + 1 + i, EV_G1 | EV_MW, 16'h0100 + 16'(i), 32'hC0DE_0000 + 32'(i), 32'h0);
    push(t + 6, EV_G0 | EV_MR, 16'h0040, 32'h0, 32'h0);
    push(t + 9, EV_RV0, 16'h0, 32'h0, 32'hA5A5_0040);
    step();
    m1_addr = 16'h0101; m1_wdata = 32'hC0DE_0001;
    m0_read = 1; m0_addr = 16'h0040;
    step(); m1_addr = 16'h0102; m1_wdata = 32'hC0DE_0002;
    @(negedge clk);
    chk("t2_owner_m1", 64'(owner), 64'h2);
    step(); m1_addr = 16'h0103; m1_wdata = 32'hC0DE_0003;
    step(); m1_write = 0; m1_lock = 0;
    step();
    @(negedge clk);
    chk("t2_owner_idle", 64'(owner), 64'h0);
    step(); m0_read = 0;
    repeat (5) step();

    // Read and write together
    step(); t = cyc;
    m0_read = 1; m0_write = 1; m0_addr = 16'h0020; m0_wdata = 32'h5;
    push(t + 1, EV_G0 | EV_MW, 16'h0020, 32'h5, 32'h0);
    step(); m0_read = 0; m0_write = 0;
    @(negedge clk);
    chk("t5_cmd_err_set", 64'(cmd_err), 64'h1);
    repeat (4) step();
    @(negedge clk);
    chk("t5_cmd_err_sticky", 64'(cmd_err), 64'h1);
    step(); rst = 1'b1;
    step(); step(); rst = 1'b0;
    @(negedge clk);
    chk("t5_cmd_err_cleared", 64'(cmd_err), 64'h0);
    chk("t5_rdata_cleared", 64'(m0_rdata), 64'h0);

    // Both requesters reading continuously, lock low
    step(); t = cyc;
    m0_read = 1; m0_addr = 16'h0200;
    m1_read = 1; m1_addr = 16'h0300;
    pid = 1'b0; paddr = 16'h0;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      wid = (k % 2 == 1);
`else
      wid = 1'b0;
`endif
      waddr = wid ? 16'h0300 : 16'h0200;
      push(t + 1 + 2 * k, (wid ? EV_G1 : EV_G0) | EV_MR, waddr, 32'h0, 32'h0);
      if (k >= 1)
        push(t + 2 + 2 * k, pid ? EV_RV1 : EV_RV0, 16'h0, 32'h0, {16'hA5A5, paddr});
      pid = wid; paddr = waddr;
    end
    push(t + 10, pid ? EV_RV1 : EV_RV0, 16'h0, 32'h0, {16'hA5A5, paddr});
    repeat (7) step();
    m0_read = 0; m1_read = 0;
    repeat (6) step();

    // Lock held past MAX_LOCK grants, m1 waiting
    step(); t = cyc;
    m0_write = 1; m0_lock = 1; m0_addr = 16'h0400; m0_wdata = 32'h44;
    m1_read = 1; m1_addr = 16'h0500;
    for (int i = 0; i < MAX_LOCK; i++)
      push(t + 1 + i, EV_G0 | EV_MW, 16'h0400, 32'h44, 32'h0);
    push(t + MAX_LOCK + 2, EV_G1 | EV_MR, 16'h0500, 32'h0, 32'h0);
    push(t + MAX_LOCK + 5, EV_RV1, 16'h0, 32'h0, 32'hA5A5_0500);
    repeat (MAX_LOCK) step();
    m0_write = 0;
    step();
    @(negedge clk);
    chk("t4_forced_release", 64'(owner), 64'h0);
    step(); m1_read = 0; m0_lock = 0;
    repeat (6) step();

    // Reset one cycle after a read issue flushes the return
    step(); t = cyc;
    m0_read = 1; m0_addr = 16'h0030;
    push(t + 1, EV_G0 | EV_MR, 16'h0030, 32'h0, 32'h0);
    step(); m0_read = 0; rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_strobes", 64'({m0_grant, m1_grant, mem_read, mem_write, m0_rvalid, m1_rvalid}), 64'h0);
    chk("t6_rst_regs", 64'({owner, mem_address}), 64'h0);
    chk("t6_rst_rdata", 64'(m0_rdata), 64'h0);
    repeat (8) step();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/knn_mem_arbiter.md
# knn_mem_arbiter

Two-requester arbiter for the single shared memory port of the KNN system. Requester 0 is the KNN memory controller (training/input reads, inferred-type writes); requester 1 is the host loader that fills training and input data. The arbiter serialises commands onto one read/write port, tracks fixed read latency and routes each read return to its issuer. It supports locked bursts so one requester can own the port across a multi-word transfer.

## Interface
- W, 32, data word width
- ADDR_W, 16, address width
- RD_LAT, 2, cycles from mem_read high to mem_readdata valid (1..8)
- MAX_LOCK, 64, maximum consecutive commands under lock before forced release
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- m0_read / m1_read  in  1  read request, held until granted
- m0_write / m1_write  in  1  write request, held until granted
- m0_lock / m1_lock  in  1  keep ownership after current grant
- m0_addr / m1_addr  in  ADDR_W  command address
- m0_wdata / m1_wdata  in  W  write data
- m0_grant / m1_grant  out  1  one-cycle pulse: command accepted
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse: read data valid
- m0_rdata / m1_rdata  out  W  read data, held until next rvalid
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  memory address
- mem_writedata  out  W  memory write data
- mem_readdata  in  W  memory read data
- owner  out  2  2'b00 none, 2'b01 m0, 2'b10 m1
- cmd_err  out  1  sticky: requester asserted read and write together

## Operation
- States: IDLE, OWN0, OWN1.
- IDLE: sample requests; pending = read|write. Only one pending -> grant it. Both pending -> tie-break (see Configuration). Enter OWNx.
- OWNx: each cycle with mx pending, issue its command and pulse mx_grant. After a grant, lock low -> IDLE; lock high -> stay. Lock high with no pending: stay, port idle.
- Lock counter counts grants in OWNx; at MAX_LOCK grants ownership releases to IDLE regardless of lock, counter clears. Counter clears on every IDLE entry.
- Read and write high together: write issued, read discarded, cmd_err set until rst.
- Return tag: RD_LAT-deep shift register of {valid, id} entered on each issued read; on emergence, mem_readdata latched into mx_rdata and mx_rvalid pulsed. Tags drain across ownership changes.
- Writes produce no rvalid.

## Timing
- Request sampled cycle t -> grant pulse, mem_read/mem_write, mem_address, mem_writedata all registered, high in t+1 (single-cycle strobe).
- Back-to-back: requester held at t, t+1 under lock -> commands at t+1, t+2 (one per cycle).
- Lock low: IDLE at t+1, next grant no earlier than t+2 (one-cycle turnaround).
- Read issued at t+1 -> mem_readdata valid at t+1+RD_LAT -> mx_rvalid and mx_rdata at t+2+RD_LAT.
- Requester must hold request and operands stable until grant; dropping early is allowed and cancels it.
- Reset values: all grants, rvalids, mem_read, mem_write, cmd_err 0; mem_address, mem_writedata, m0/m1_rdata 0; owner 2'b00; state IDLE; tag pipeline empty.
- Reset mid-operation: outstanding read tags flushed, no rvalid emitted for them.

## Configuration
- ARB_ROUND_ROBIN_EN defined: tie in IDLE goes to the requester not granted most recently (last-grant register reset to m1, so first tie -> m0).
- Not defined: fixed priority, m0 always wins ties; m1 can starve while m0 keeps requesting.

## Test plan
- m0 read addr 0x0010, memory returns 0xDEADBEEF, RD_LAT=2 -> m0_grant at t+1, mem_read one cycle at t+1, m0_rvalid with 0xDEADBEEF at t+4; m1_rvalid stays 0.
- m1 locked 4-word burst writes 0x0100..0x0103 with m0 read pending -> four consecutive mem_write cycles, then IDLE, m0 granted two cycles after last m1 grant.
- m0 and m1 both read every cycle, lock low -> with ARB_ROUND_ROBIN_EN grants alternate m0,m1,m0,...; without it only m0 granted.
- m0 lock held, continuous requests, MAX_LOCK=64, m1 pending -> exactly 64 m0 grants, then IDLE, m1 granted.
- m0 read and write same cycle addr 0x0020 data 0x5 -> single mem_write to 0x0020, no mem_read, cmd_err=1 until rst.
- rst asserted one cycle after a read issue -> no rvalid ever emitted, all outputs at reset values next cycle.
